// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: serialises W-bit words MSB first on sck/mosi/cs_n and
// captures miso, with a valid/ready host interface and optional held chip select.
module spi_initiator #(
  parameter int DIV = 2,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tx_data,
  input  logic         tx_hold,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic [W-1:0] rx_data,
  output logic         rx_valid,
  output logic         busy,
  output logic         sck,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  localparam int HCW = $clog2(DIV) + 1;
  localparam int BCW = $clog2(W) + 1;
  localparam logic [HCW-1:0] H_LAST = HCW'(DIV - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HELD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           sck_q, sck_d;
  logic           hold_q, hold_d;
  logic [W-1:0]   tx_sh_q, tx_sh_d;
  logic [W-1:0]   rx_sh_q, rx_sh_d;
  logic [W-1:0]   rx_data_q, rx_data_d;
  logic           rx_valid_q, rx_valid_d;
  logic           accept;

  assign tx_ready = (state_q == S_IDLE) || (state_q == S_HELD);
  assign busy     = (state_q != S_IDLE);
  assign cs_n     = (state_q == S_IDLE) || (state_q == S_GAP);
  assign mosi     = cs_n ? 1'b0 : tx_sh_q[W-1];
  assign sck      = sck_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign accept   = tx_valid & tx_ready;

  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    sck_d      = sck_q;
    hold_d     = hold_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      S_IDLE, S_HELD: begin
        if (accept) begin
          state_d = S_LEAD;
          tx_sh_d = tx_data;
          hold_d  = tx_hold;
          hcnt_d  = '0;
        end
      end
      S_LEAD: begin
        if (hcnt_q == H_LAST) begin
          state_d = S_SHIFT;
          hcnt_d  = '0;
          bcnt_d  = '0;
          sck_d   = 1'b1;
          rx_sh_d = W'({rx_sh_q, miso});
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (hcnt_q != H_LAST) begin
          hcnt_d = hcnt_q + 1'b1;
        end else begin
          hcnt_d = '0;
          if (sck_q) begin
            // Falling edge: advance mosi except after the last bit, which stays put.
            sck_d = 1'b0;
            if (bcnt_q != B_LAST) tx_sh_d = tx_sh_q << 1;
          end else if (bcnt_q == B_LAST) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            state_d    = hold_q ? S_HELD : S_GAP;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            sck_d   = 1'b1;
            rx_sh_d = W'({rx_sh_q, miso});
          end
        end
      end
      S_GAP: begin
        if (hcnt_q == H_LAST) begin
          state_d = S_IDLE;
          hcnt_d  = '0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hcnt_q     <= '0;
      bcnt_q     <= '0;
      sck_q      <= 1'b0;
      hold_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      sck_q      <= sck_d;
      hold_q     <= hold_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_initiator.sv
// Bench for spi_initiator: a DIV=2/W=8 instance with a mode-0 slave model and a
// DIV=1/W=16 loopback instance, checked against frame-level timing and data rules.
module tb_spi_initiator;

  localparam int DIV_A = 2;
  localparam int W_A   = 8;
  localparam int LAT_A = DIV_A * (1 + 2 * W_A) + 1;
  localparam int CSL_A = DIV_A * (1 + 2 * W_A);
  localparam int DIV_B = 1;
  localparam int W_B   = 16;
  localparam int LAT_B = DIV_B * (1 + 2 * W_B) + 1;
  localparam int CSL_B = DIV_B * (1 + 2 * W_B);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  tx_data_a = '0;
  logic        tx_hold_a = 1'b0, tx_valid_a = 1'b0;
  logic        tx_ready_a, rx_valid_a, busy_a, sck_a, mosi_a, miso_a, cs_n_a;
  logic [7:0]  rx_data_a;
  logic [15:0] tx_data_b = '0;
  logic        tx_valid_b = 1'b0;
  logic        tx_ready_b, rx_valid_b, busy_b, sck_b, mosi_b, miso_b, cs_n_b;
  logic [15:0] rx_data_b;

  spi_initiator #(.DIV(DIV_A), .W(W_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_hold(tx_hold_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .rx_data(rx_data_a),
    .rx_valid(rx_valid_a), .busy(busy_a), .sck(sck_a), .mosi(mosi_a),
    .miso(miso_a), .cs_n(cs_n_a));

  spi_initiator #(.DIV(DIV_B), .W(W_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_hold(1'b0),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .rx_data(rx_data_b),
    .rx_valid(rx_valid_b), .busy(busy_b), .sck(sck_b), .mosi(mosi_b),
    .miso(miso_b), .cs_n(cs_n_b));

  assign miso_b = mosi_b;

  // Mode-0 slave: captures mosi on sck rise, advances its reply on sck fall.
  logic       loopback = 1'b1;
  logic [7:0] slv_tx = '0, slv_rx = '0;
  assign miso_a = loopback ? mosi_a : slv_tx[7];
  always @(posedge sck_a) slv_rx = {slv_rx[6:0], mosi_a};
  always @(negedge sck_a) slv_tx = {slv_tx[6:0], 1'b0};

  int   rises_a = 0, cs_run_a = 0, cs_last_a = 0, hi_run_a = 0, hi_min_a = 1000;
  int   mosi_bad_a = 0, rxv_cnt_a = 0, rxv_dbl_a = 0;
  logic prev_sck_a = 1'b0, prev_cs_a = 1'b1, prev_mosi_a = 1'b0, prev_rxv_a = 1'b0;
  int   rises_b = 0, highs_b = 0, cs_run_b = 0, cs_last_b = 0;
  logic prev_sck_b = 1'b0, prev_cs_b = 1'b1;

  always @(negedge clk) begin
    if (sck_a && !prev_sck_a) rises_a++;
    if (!cs_n_a) begin
      cs_run_a++;
      if (prev_cs_a && hi_run_a < hi_min_a) hi_min_a = hi_run_a;
      hi_run_a = 0;
    end else begin
      if (!prev_cs_a) cs_last_a = cs_run_a;
      cs_run_a = 0;
      hi_run_a++;
    end
    if (mosi_a !== prev_mosi_a && sck_a) mosi_bad_a++;
    if (cs_n_a && mosi_a) mosi_bad_a++;
    if (rx_valid_a) rxv_cnt_a++;
    if (rx_valid_a && prev_rxv_a) rxv_dbl_a++;
    prev_sck_a = sck_a; prev_cs_a = cs_n_a; prev_mosi_a = mosi_a; prev_rxv_a = rx_valid_a;

    if (sck_b && !prev_sck_b) rises_b++;
    if (sck_b) highs_b++;
    if (!cs_n_b) cs_run_b++;
    else begin
      if (!prev_cs_b) cs_last_b = cs_run_b;
      cs_run_b = 0;
    end
    prev_sck_b = sck_b; prev_cs_b = cs_n_b;
  end

  int errors = 0, checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready_a();
    int n = 0;
    while (!tx_ready_a && n < 200) begin @(negedge clk); #1; n++; end
    if (!tx_ready_a) check("tx_ready_timeout", 32'(tx_ready_a), 32'd1);
  endtask

  logic [7:0] got_rx, got_slave;
  logic       got_rxv, got_cs, got_ready, got_busy, got_pulse2;
  int         got_lat, got_rises, got_cslast;

  task automatic run_a(input logic [7:0] d, input logic h, input logic [7:0] resp, input logic lb);
    int r0;
    loopback = lb;
    slv_tx = resp;
    wait_ready_a();
    r0 = rises_a;
    tx_data_a = d; tx_hold_a = h; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    tx_valid_a = 1'b0; tx_data_a = 8'($urandom); tx_hold_a = 1'($urandom);
    got_lat = 0; got_rxv = 1'b0;
    while (got_lat < 200) begin
      @(negedge clk); #1; got_lat++;
      if (rx_valid_a) begin got_rxv = 1'b1; break; end
    end
    got_rx = rx_data_a; got_cs = cs_n_a; got_ready = tx_ready_a; got_busy = busy_a;
    got_rises = rises_a - r0; got_cslast = cs_last_a; got_slave = slv_rx;
    @(negedge clk); #1;
    got_pulse2 = rx_valid_a;
    tx_hold_a = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [7:0] resp;
    logic       lb;
    logic [7:0] exp_rx;
    logic [7:0] exp_slv;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] d, r, g1, g2;
    logic       h, rdy1, cs_after, seen, dropnext;
    int n, r0, c0, pulses, csbreak, cl, bad, hb0;

    vecs[0] = '{8'hA5, 8'h00, 1'b1, 8'hA5, 8'hA5};
    vecs[1] = '{8'h96, 8'h3C, 1'b0, 8'h3C, 8'h96};
    vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF, 8'h00};
    vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h01, 8'h80};
    vecs[5] = '{8'h01, 8'h00, 1'b1, 8'h01, 8'h01};

    #1;
    check("rst_sck",      32'(sck_a), 32'd0);
    check("rst_mosi",     32'(mosi_a), 32'd0);
    check("rst_cs_n",     32'(cs_n_a), 32'd1);
    check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check("rst_rx_data",  32'(rx_data_a), 32'd0);
    check("rst_busy",     32'(busy_a), 32'd0);
    check("rst_b_cs_n",   32'(cs_n_b), 32'd1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i].d, 1'b0, vecs[i].resp, vecs[i].lb);
      check($sformatf("vec%0d_rx_valid", i), 32'(got_rxv), 32'd1);
      check($sformatf("vec%0d_rx_data", i), 32'(got_rx), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_slave_rx", i), 32'(got_slave), 32'(vecs[i].exp_slv));
      check($sformatf("vec%0d_latency", i), 32'(got_lat), 32'(LAT_A));
      check($sformatf("vec%0d_sck_rises", i), 32'(got_rises), 32'(W_A));
      check($sformatf("vec%0d_cs_low", i), 32'(got_cslast), 32'(CSL_A));
      check($sformatf("vec%0d_cs_at_rxv", i), 32'(got_cs), 32'd1);
      check($sformatf("vec%0d_pulse_len", i), 32'(got_pulse2), 32'd0);
    end

    // Held frame: 0x12 with hold, then 0x34 accepted from HELD while tx_valid stays high.
    loopback = 1'b1;
    wait_ready_a();
    r0 = rises_a;
    tx_data_a = 8'h12; tx_hold_a = 1'b1; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    tx_data_a = 8'h34; tx_hold_a = 1'b0;
    pulses = 0; csbreak = 0; n = 0; dropnext = 1'b0;
    g1 = '0; g2 = '0; rdy1 = 1'b0; cs_after = 1'b0; cl = 0;
    while (pulses < 2 && n < 300) begin
      @(negedge clk); #1; n++;
      if (dropnext) begin tx_valid_a = 1'b0; dropnext = 1'b0; end
      if (rx_valid_a) begin
        pulses++;
        if (pulses == 1) begin g1 = rx_data_a; rdy1 = tx_ready_a; dropnext = 1'b1; end
        else begin g2 = rx_data_a; cs_after = cs_n_a; cl = cs_last_a; end
      end
      if (cs_n_a && pulses < 2) csbreak++;
    end
    tx_valid_a = 1'b0;
    check("held_pulses", 32'(pulses), 32'd2);
    check("held_rx1", 32'(g1), 32'h12);
    check("held_ready_in_held", 32'(rdy1), 32'd1);
    check("held_rx2", 32'(g2), 32'h34);
    check("held_cs_breaks", 32'(csbreak), 32'd0);
    check("held_cs_high_after", 32'(cs_after), 32'd1);
    check("held_sck_rises", 32'(rises_a - r0), 32'(2 * W_A));
    check("held_cs_low_len", 32'(cl), 32'(2 * CSL_A + 1));

    // tx_valid held high with churning tx_data: only the accepted word shifts.
    wait_ready_a();
    loopback = 1'b1;
    tx_data_a = 8'h81; tx_hold_a = 1'b0; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    bad = 0; n = 0; seen = 1'b0; g1 = '0;
    while (!seen && n < 200) begin
      tx_data_a = 8'($urandom); tx_hold_a = 1'($urandom);
      @(negedge clk); #1; n++;
      if (tx_ready_a) bad++;
      if (rx_valid_a) begin seen = 1'b1; g1 = rx_data_a; end
    end
    @(negedge clk); #1;
    if (tx_ready_a) bad++;
    tx_valid_a = 1'b0; tx_hold_a = 1'b0;
    @(negedge clk); #1;
    check("churn_rx_valid", 32'(seen), 32'd1);
    check("churn_rx_data", 32'(g1), 32'h81);
    check("churn_ready_low_cycles", 32'(bad), 32'd0);
    check("churn_idle_ready", 32'(tx_ready_a), 32'd1);
    check("churn_idle_busy", 32'(busy_a), 32'd0);

    // Asynchronous reset after the third sck rise.
    wait_ready_a();
    loopback = 1'b1;
    r0 = rises_a; c0 = rxv_cnt_a;
    tx_data_a = 8'hC3; tx_hold_a = 1'b0; tx_valid_a = 1'b1;
    @(posedge clk); #1;
    tx_valid_a = 1'b0;
    n = 0;
    while (rises_a - r0 < 3 && n < 100) begin @(negedge clk); #1; n++; end
    check("arst_reached_rise3", 32'(rises_a - r0), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(cs_n_a), 32'd1);
    check("arst_sck", 32'(sck_a), 32'd0);
    check("arst_mosi", 32'(mosi_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_rx_data", 32'(rx_data_a), 32'd0);
    repeat (40) @(negedge clk);
    #1;
    check("arst_no_rx_valid", 32'(rxv_cnt_a - c0), 32'd0);
    rst_n = 1'b1;
    run_a(8'h5A, 1'b0, 8'h00, 1'b1);
    check("arst_after_rx", 32'(got_rx), 32'h5A);
    check("arst_after_latency", 32'(got_lat), 32'(LAT_A));
    check("arst_after_pulses", 32'(rxv_cnt_a - c0), 32'd1);

    // DIV=1, W=16 loopback.
    r0 = rises_b; hb0 = highs_b;
    tx_data_b = 16'hBEEF; tx_valid_b = 1'b1;
    @(posedge clk); #1;
    tx_valid_b = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk); #1; n++;
      if (rx_valid_b) seen = 1'b1;
    end
    check("b_rx_valid", 32'(seen), 32'd1);
    check("b_rx_data", 32'(rx_data_b), 32'hBEEF);
    check("b_latency", 32'(n), 32'(LAT_B));
    check("b_sck_rises", 32'(rises_b - r0), 32'(W_B));
    check("b_sck_high_cycles", 32'(highs_b - hb0), 32'(W_B));
    check("b_cs_low", 32'(cs_last_b), 32'(CSL_B));

    // Random words against a slave model, with random chip-select holding.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom); r = 8'($urandom);
      h = (i == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      run_a(d, h, r, 1'b0);
      check($sformatf("rnd%0d_rx_data", i), 32'(got_rx), 32'(r));
      check($sformatf("rnd%0d_slave_rx", i), 32'(got_slave), 32'(d));
      check($sformatf("rnd%0d_latency", i), 32'(got_lat), 32'(LAT_A));
      check($sformatf("rnd%0d_sck_rises", i), 32'(got_rises), 32'(W_A));
      check($sformatf("rnd%0d_cs_at_rxv", i), 32'(got_cs), 32'(!h));
      check($sformatf("rnd%0d_ready_at_rxv", i), 32'(got_ready), 32'(h));
      check($sformatf("rnd%0d_busy_at_rxv", i), 32'(got_busy), 32'd1);
    end
    repeat (6) @(negedge clk);
    #1;

    check("mosi_rules_violations", 32'(mosi_bad_a), 32'd0);
    check("rx_valid_back_to_back", 32'(rxv_dbl_a), 32'd0);
    check("min_cs_high_ge_div", 32'(hi_min_a >= DIV_A), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
